// File: rtl/comar_rand_pkg.sv
// Shared constants and types for COMAR gadget mask sources.
//   TAPS           : Galois feedback taps for x^32+x^22+x^2+x+1
//   STEPS_PER_WORD : serial LFSR shifts per delivered output word
//   state_e        : mask source seeding state
package comar_rand_pkg;

  localparam logic [31:0] TAPS           = 32'h8020_0003;
  localparam int unsigned STEPS_PER_WORD = 7;

  typedef enum logic [1:0] {
    UNSEEDED,
    RUN,
    EXHAUSTED
  } state_e;

endpackage

// File: rtl/comar_lfsr_step.sv
// Purely combinational advance of a 32-bit Galois LFSR by one output word
// (STEPS_PER_WORD serial right shifts with feedback TAPS).
// Ports:
//   state_in  : current LFSR state
//   state_out : state after STEPS_PER_WORD shifts
module comar_lfsr_step
  import comar_rand_pkg::*;
(
  input  logic [31:0] state_in,
  output logic [31:0] state_out
);

  logic [31:0] s;

  always_comb begin
    s = state_in;
    for (int i = 0; i < int'(STEPS_PER_WORD); i++) begin
      s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    end
    state_out = s;
  end

endmodule

// File: rtl/comar_mask_source.sv
// Randomness producer for a bank of two-share COMAR gadgets. Delivers fresh
// masks r every advance and a shared common_out mask bit that only changes on
// common_update. A seeded Galois LFSR is rate-limited to RESEED_PERIOD advances
// per seed; after that the outputs are flagged unusable until reseeded.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   seed_valid    : seed_data offered
//   seed_ready    : always 1; a seed is accepted in every state
//   seed_data     : new LFSR seed (zero is substituted by SEED_SUBST)
//   en            : advance the LFSR one word (RUN only)
//   common_update : resample common_out from pre-advance lfsr_q[31] (RUN only)
//   r             : fresh masks, low RAND_W bits of the LFSR state
//   common_out    : shared output mask bit
//   rand_valid    : r / common_out usable
//   reseed_req    : a new seed is required
module comar_mask_source
  import comar_rand_pkg::*;
#(
  parameter int unsigned LFSR_W        = 32,
  parameter int unsigned RAND_W        = 6,
  parameter int unsigned RESEED_PERIOD = 1024,
  parameter logic [31:0] SEED_SUBST    = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic [31:0]       seed_data,
  input  logic              en,
  input  logic              common_update,
  output logic [RAND_W-1:0] r,
  output logic              common_out,
  output logic              rand_valid,
  output logic              reseed_req
);

  localparam int unsigned    CntW   = $clog2(RESEED_PERIOD + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(RESEED_PERIOD);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_next;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                common_q, common_d;
  logic                seed_take;

  comar_lfsr_step u_step (
    .state_in  (lfsr_q),
    .state_out (lfsr_next)
  );

  assign seed_ready = 1'b1;
  assign seed_take  = seed_valid & seed_ready;

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    cnt_d    = cnt_q;
    common_d = common_q;
    // A seed pre-empts any en/common_update in the same cycle.
    if (seed_take) begin
      lfsr_d  = (seed_data == '0) ? SEED_SUBST : seed_data;
      cnt_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (common_update) begin
        common_d = lfsr_q[LFSR_W-1];
      end
      if (en) begin
        lfsr_d = lfsr_next;
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (cnt_d == CntMax) begin
          state_d = EXHAUSTED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNSEEDED;
      lfsr_q   <= '0;
      cnt_q    <= '0;
      common_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      common_q <= common_d;
    end
  end

  // Validity is a pure function of the registered state, so it follows the
  // same one-cycle timing as the seed/advance that changed it.
  assign r          = lfsr_q[RAND_W-1:0];
  assign common_out = common_q;
  assign rand_valid = (state_q == RUN);
  assign reseed_req = (state_q != RUN);

endmodule
